// File: rtl/uart_rx_buf_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_buf_ctrl_pkg
// Description : Shared defaults and width helper for the UART RX buffer path.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_buf_ctrl_pkg;

    localparam int c_DATA_W_DEFAULT = 8;
    localparam int c_DEPTH_DEFAULT  = 16;

    // Count must hold 0..DEPTH inclusive, hence one bit more than the pointer.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_buf_ctrl_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_buf_ctrl_fifo
// Description : Synchronous first-word-fall-through FIFO with occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_buf_ctrl_fifo
    import uart_rx_buf_ctrl_pkg::*;
#(
    parameter  int DATA_W = c_DATA_W_DEFAULT,
    parameter  int DEPTH  = c_DEPTH_DEFAULT,
    localparam int CNT_W  = cnt_width(DEPTH),
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  count_next,
    output logic              full,
    output logic              empty
);

    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] c_PTR1 = PTR_W'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_next;

    always_comb begin
        w_count_next = r_count;
        case ({push, pop})
            2'b10:   w_count_next = r_count + c_ONE;
            2'b01:   w_count_next = r_count - c_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // Storage is not reset; contents are meaningless while count is zero.
    always_ff @(posedge CLK) begin
        if (push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + c_PTR1;
            if (pop)  r_rd_ptr <= r_rd_ptr + c_PTR1;
            r_count <= w_count_next;
        end
    end

    assign rd_data    = r_mem[r_rd_ptr];
    assign count      = r_count;
    assign count_next = w_count_next;
    assign full       = (r_count == c_FULL);
    assign empty      = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/uart_rx_buf_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_buf_ctrl
// Description : UART RX buffer controller: FIFO, valid/ready output, RX throttle
//               and sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_buf_ctrl
    import uart_rx_buf_ctrl_pkg::*;
#(
    parameter  int DATA_W        = c_DATA_W_DEFAULT,
    parameter  int DEPTH         = c_DEPTH_DEFAULT,
    parameter  int PAUSE_ON_FULL = 1,
    localparam int CNT_W         = cnt_width(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              Rx_Done_Sig,
    input  logic [DATA_W-1:0] Rx_Data,
    output logic              Rx_En_Sig,
    output logic [DATA_W-1:0] Out_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [CNT_W-1:0]  Fifo_Count,
    output logic              Overflow,
    input  logic              Clr_Ovf
);

    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(DEPTH);

    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic             w_hold_full;
    logic             w_drop;
    logic [CNT_W-1:0] w_count_next;
    logic             r_rx_en;
    logic             r_overflow;

    assign w_pop  = ~w_empty & Out_Ready;
    // A simultaneous pop frees a slot, so a full FIFO can still accept the word.
    assign w_push = Rx_Done_Sig & (~w_full | w_pop);
    assign w_drop = Rx_Done_Sig & w_full & ~w_pop;

    uart_rx_buf_ctrl_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .push       (w_push),
        .pop        (w_pop),
        .wr_data    (Rx_Data),
        .rd_data    (Out_Data),
        .count      (Fifo_Count),
        .count_next (w_count_next),
        .full       (w_full),
        .empty      (w_empty)
    );

    generate
        if (PAUSE_ON_FULL != 0) begin : g_pause_on_full
            assign w_hold_full = (w_count_next == c_FULL);
        end else begin : g_never_pause
            assign w_hold_full = 1'b0;
        end
    endgenerate

    // One-cycle re-arm gap after every completed word, plus optional back-pressure.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_rx_en <= 1'b0;
        end else begin
            r_rx_en <= ~Rx_Done_Sig & ~w_hold_full;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (Clr_Ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign Rx_En_Sig = r_rx_en;
    assign Overflow  = r_overflow;
    assign Out_Valid = ~w_empty;

endmodule
`default_nettype wire
